// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial link transmitter and the matching deframer.
package serial_link_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        SOF      = 3'd2,
        DATA     = 3'd3,
        EOF      = 3'd4
    } tx_state_t;

    // Frame flag as a vector where bit k is the k-th line bit sent:
    // a 0, then max_run+1 ones, then a 0 (max_run+3 bits in total).
    function automatic logic [31:0] flag_bits(input int max_run);
        return ((32'd1 << (max_run + 1)) - 32'd1) << 1;
    endfunction

endpackage

// File: rtl/serial_link_bit_timer.sv
// Line bit divider: one bit_tick every CLKS_PER_BIT clocks while enabled.
module serial_link_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bit_tick
);

    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] count;

    // Count 0..CLKS_PER_BIT-1 while enabled; parked at 0 otherwise so each frame starts on a full bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!en || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign bit_tick = en && (count == LAST);

endmodule

// File: rtl/serial_link_tx.sv
// NRZ frame transmitter: preamble, start flag, bit-stuffed LSB-first data, end flag.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | line parked at 0, waiting for a word in the holding register
// PREAMBLE | alternating 1,0,... training bits for receiver clock recovery
// SOF      | start flag 0 1..1 0
// DATA     | data bits LSB first, complement stuff bit after each max run
// EOF      | end flag, then back to IDLE
module serial_link_tx
    import serial_link_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int CLKS_PER_BIT   = 4,
    parameter int PREAMBLE_EDGES = 20,
    parameter int MAX_RUN        = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              serial_out,
    output logic              busy
);

    localparam int FLAG_LEN = MAX_RUN + 3;
    localparam logic [31:0] FLAG = flag_bits(MAX_RUN);
    localparam int CNT_MAX_PF = (PREAMBLE_EDGES > FLAG_LEN) ? PREAMBLE_EDGES : FLAG_LEN;
    localparam int CNT_MAX = (CNT_MAX_PF > DATA_W) ? CNT_MAX_PF : DATA_W;
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam int RUN_W = $clog2(MAX_RUN + 1);

    tx_state_t         state;
    logic [DATA_W-1:0] hold_reg;
    logic [DATA_W-1:0] shifter;
    logic              hold_full;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  nxt_idx;
    logic [RUN_W-1:0]  run_len;
    logic              run_val;
    logic              bit_tick;
    logic              timer_en;
    logic              fill;
    logic              drain;
    logic              stuff_due;
    logic              word_done;
    logic              flag_next;
    logic              new_bit;
    logic              extend;

    assign timer_en = (state != IDLE);
    assign busy     = timer_en;
    assign tx_ready = !hold_full;
    assign fill     = tx_valid && !hold_full;

    serial_link_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .en      (timer_en),
        .bit_tick(bit_tick)
    );

    // Next-bit decisions shared by the FSM and the holding register.
    always_comb begin
        stuff_due = (run_len == RUN_W'(MAX_RUN));
        word_done = (bit_cnt == CNT_W'(DATA_W));
        nxt_idx   = bit_cnt + 1'b1;
        flag_next = |(FLAG & (32'd1 << nxt_idx));
        new_bit   = ((state == DATA) && !word_done) ? shifter[0] : hold_reg[0];
        extend    = (run_len != '0) && (new_bit == run_val);
        drain     = bit_tick && hold_full &&
                    (((state == SOF) && (bit_cnt == CNT_W'(FLAG_LEN - 1))) ||
                     ((state == DATA) && !stuff_due && word_done));
    end

    // One-word holding register; a fill always wins over a drain in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_full <= 1'b0;
            hold_reg  <= '0;
        end else if (fill) begin
            hold_full <= 1'b1;
            hold_reg  <= tx_data;
        end else if (drain) begin
            hold_full <= 1'b0;
        end
    end

    // Frame sequencer: the line only moves on bit ticks, except the first preamble bit on frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            serial_out <= 1'b0;
            bit_cnt    <= '0;
            shifter    <= '0;
            run_len    <= '0;
            run_val    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    serial_out <= 1'b0;
                    if (hold_full) begin
                        state      <= PREAMBLE;
                        serial_out <= 1'b1;
                        bit_cnt    <= '0;
                    end
                end
                PREAMBLE: if (bit_tick) begin
                    if (bit_cnt == CNT_W'(PREAMBLE_EDGES - 1)) begin
                        state      <= SOF;
                        bit_cnt    <= '0;
                        run_len    <= '0;
                        serial_out <= FLAG[0];
                    end else begin
                        bit_cnt    <= nxt_idx;
                        serial_out <= !serial_out;
                    end
                end
                SOF, EOF: if (bit_tick) begin
                    if (bit_cnt == CNT_W'(FLAG_LEN - 1)) begin
                        if (state == SOF) begin
                            state      <= DATA;
                            serial_out <= new_bit;
                            shifter    <= hold_reg >> 1;
                            bit_cnt    <= CNT_W'(1);
                            run_val    <= new_bit;
                            run_len    <= extend ? run_len + 1'b1 : RUN_W'(1);
                        end else begin
                            state      <= IDLE;
                            serial_out <= 1'b0;
                            bit_cnt    <= '0;
                        end
                    end else begin
                        bit_cnt    <= nxt_idx;
                        serial_out <= flag_next;
                    end
                end
                DATA: if (bit_tick) begin
                    if (stuff_due) begin
                        serial_out <= !run_val;
                        run_val    <= !run_val;
                        run_len    <= RUN_W'(1);
                    end else if (word_done && !hold_full) begin
                        state      <= EOF;
                        bit_cnt    <= '0;
                        serial_out <= FLAG[0];
                    end else begin
                        // Runs carry across word boundaries, so a new word just continues the run count.
                        serial_out <= new_bit;
                        shifter    <= word_done ? (hold_reg >> 1) : (shifter >> 1);
                        bit_cnt    <= word_done ? CNT_W'(1) : nxt_idx;
                        run_val    <= new_bit;
                        run_len    <= extend ? run_len + 1'b1 : RUN_W'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    serial_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_link_tx.sv
// Bench for serial_link_tx: frame-level reference model, per-cycle line compare and a reference deframer.
module tb_serial_link_tx;

    localparam int DATA_W  = 8;
    localparam int CPB     = 4;
    localparam int PRE     = 20;
    localparam int MAX_RUN = 5;
    localparam int FLEN    = MAX_RUN + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       serial_out;
    logic       busy;

    serial_link_tx #(
        .DATA_W(DATA_W), .CLKS_PER_BIT(CPB), .PREAMBLE_EDGES(PRE), .MAX_RUN(MAX_RUN)
    ) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .serial_out(serial_out), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic so; logic bz; logic smp; } exp_t;

    int         total = 0;
    int         bad = 0;
    exp_t       exp_q[$];
    exp_t       cmp_e;
    logic       cap_q[$];
    logic       exp_bits[$];
    logic [7:0] tx_words[$];
    bit         chk_en = 1'b0;
    bit         ready_low_seen = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void push_flag();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < MAX_RUN + 1; i++) exp_bits.push_back(1'b1);
        exp_bits.push_back(1'b0);
    endfunction

    // Whole frame as line bits, built straight from the framing rules.
    function automatic void build_model();
        int   rl;
        logic rv;
        logic d;
        exp_bits.delete();
        for (int i = 0; i < PRE; i++) exp_bits.push_back((i % 2) == 0);
        push_flag();
        rl = 0;
        rv = 1'b0;
        foreach (tx_words[w]) begin
            for (int b = 0; b < DATA_W; b++) begin
                d = tx_words[w][b];
                if (rl > 0 && d == rv) rl++;
                else begin rv = d; rl = 1; end
                exp_bits.push_back(d);
                if (rl == MAX_RUN) begin
                    rv = ~rv;
                    rl = 1;
                    exp_bits.push_back(rv);
                end
            end
        end
        push_flag();
    endfunction

    function automatic logic [63:0] pack_bits();
        logic [63:0] acc = '0;
        foreach (exp_bits[i]) acc = {acc[62:0], exp_bits[i]};
        return acc;
    endfunction

    function automatic bit is_flag(input int i);
        if (i + FLEN > cap_q.size()) return 1'b0;
        if (cap_q[i] != 1'b0 || cap_q[i + FLEN - 1] != 1'b0) return 1'b0;
        for (int k = 1; k <= MAX_RUN + 1; k++) if (cap_q[i + k] != 1'b1) return 1'b0;
        return 1'b1;
    endfunction

    // Per-cycle compare of the line and busy against the expected-cycle queue; idle rules when it is empty.
    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_q.size() != 0) begin
                cmp_e = exp_q.pop_front();
                check("line", serial_out, cmp_e.so);
                check("busy", busy, cmp_e.bz);
                if (cmp_e.smp) cap_q.push_back(serial_out);
            end else begin
                check("idle_line", serial_out, 1'b0);
                check("idle_busy", busy, 1'b0);
                check("idle_ready", tx_ready, 1'b1);
            end
        end
    end

    // Reference deframer on the captured line: find SOF, destuff, stop at EOF, compare payload.
    task automatic deframe_check();
        int   p, rl, raw_run, max_raw, nb;
        logic rv, prev, b;
        bit   eof, bad_stuff;
        logic [7:0] w;
        logic pay[$];
        p = -1;
        for (int i = 0; i + FLEN <= cap_q.size(); i++) begin
            if (is_flag(i)) begin p = i + FLEN; break; end
        end
        check("sof_found", (p >= 0), 1'b1);
        if (p < 0) return;
        check("sof_position", p, PRE + FLEN);
        rl = 0; rv = 1'b0; raw_run = 0; max_raw = 0; prev = 1'b0; eof = 1'b0; bad_stuff = 1'b0;
        while (p + FLEN <= cap_q.size()) begin
            if (is_flag(p)) begin eof = 1'b1; break; end
            b = cap_q[p];
            if (raw_run > 0 && b == prev) raw_run++; else raw_run = 1;
            prev = b;
            if (raw_run > max_raw) max_raw = raw_run;
            if (rl == MAX_RUN) begin
                if (b == rv) bad_stuff = 1'b1;
                rv = b;
                rl = 1;
            end else begin
                if (rl > 0 && b == rv) rl++;
                else begin rv = b; rl = 1; end
                pay.push_back(b);
            end
            p++;
        end
        check("eof_found", eof, 1'b1);
        check("eof_at_end", p + FLEN, cap_q.size());
        check("stuff_complement", bad_stuff, 1'b0);
        check("data_run_le_max", (max_raw <= MAX_RUN), 1'b1);
        check("payload_bits", pay.size(), DATA_W * tx_words.size());
        if (pay.size() == DATA_W * tx_words.size()) begin
            nb = 0;
            foreach (tx_words[k]) begin
                for (int j = 0; j < DATA_W; j++) w[j] = pay[nb + j];
                nb += DATA_W;
                check("payload_word", w, tx_words[k]);
            end
        end
    endtask

    task automatic wait_frame();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 5000) begin
            @(posedge clk);
            guard++;
        end
        #2;
        check("frame_drained", exp_q.size(), 0);
        exp_q.delete();
        deframe_check();
    endtask

    // Hand over all of tx_words with tx_valid held high; called at posedge+2.
    task automatic send_frame(input bit wait_done);
        int guard;
        bit rdy;
        build_model();
        cap_q.delete();
        for (int k = 0; k < tx_words.size(); k++) begin
            tx_data  = tx_words[k];
            tx_valid = 1'b1;
            guard    = 0;
            forever begin
                rdy = tx_ready;
                if (!rdy) ready_low_seen = 1'b1;
                @(posedge clk);
                if (rdy) break;
                #2;
                guard++;
                if (guard > 3000) begin
                    $display("FAIL handshake_timeout: actual=tx_ready stuck low required=handshake");
                    bad++;
                    $display("test done: total=%0d bad=%0d", total, bad);
                    $fatal(1, "handshake timeout");
                end
            end
            if (k == 0) begin
                exp_q.push_back('{so: 1'b0, bz: 1'b0, smp: 1'b0});
                foreach (exp_bits[i])
                    for (int c = 0; c < CPB; c++)
                        exp_q.push_back('{so: exp_bits[i], bz: 1'b1, smp: (c == CPB / 2)});
            end
            #2;
        end
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        if (wait_done) wait_frame();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check("rst_line", serial_out, 1'b0);
        check("rst_ready", tx_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Pin the model against hand-written frames.
        tx_words = '{8'hA5};
        build_model();
        check("model_a5_len", exp_bits.size(), 44);
        check("model_a5_bits", pack_bits(), 64'(44'b10101010101010101010_01111110_10100101_01111110));
        tx_words = '{8'hFF};
        build_model();
        check("model_ff_len", exp_bits.size(), 45);
        check("model_ff_bits", pack_bits(), 64'(45'b10101010101010101010_01111110_111110111_01111110));
        tx_words = '{8'h00, 8'h00};
        build_model();
        check("model_0000_len", exp_bits.size(), 55);
        check("model_0000_bits", pack_bits(),
              64'(55'b10101010101010101010_01111110_0000010000010000010_01111110));

        // Idle after reset.
        repeat (100) @(posedge clk);
        #2;

        tx_words = '{8'hA5};
        send_frame(1'b1);
        tx_words = '{8'hFF};
        send_frame(1'b1);
        tx_words = '{8'h00, 8'h00};
        send_frame(1'b1);

        ready_low_seen = 1'b0;
        tx_words = '{8'h3C, 8'hE1, 8'h7F};
        send_frame(1'b1);
        check("ready_low_while_full", ready_low_seen, 1'b1);

        // Random frames of 1..4 words with random idle gaps.
        for (int f = 0; f < 10; f++) begin
            tx_words.delete();
            for (int k = 0; k < int'($urandom_range(1, 4)); k++) tx_words.push_back(8'($urandom));
            send_frame(1'b1);
            repeat ($urandom_range(0, 15)) @(posedge clk);
            #2;
        end

        // Reset in the middle of DATA with a second word waiting in the holding register.
        tx_words = '{8'($urandom), 8'($urandom)};
        send_frame(1'b0);
        repeat (6) @(posedge clk);
        #2;
        check("busy_before_rst", busy, 1'b1);
        chk_en = 1'b0;
        rst    = 1'b1;
        #1;
        check("midrst_line", serial_out, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ready", tx_ready, 1'b1);
        exp_q.delete();
        cap_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst    = 1'b0;
        chk_en = 1'b1;
        repeat (30) @(posedge clk);
        #2;
        tx_words = '{8'($urandom)};
        send_frame(1'b1);
        repeat (10) @(posedge clk);
        #2;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
